// File: rtl/fft_out_serializer.sv
// fft_out_serializer: captures a 16-bin complex spectrum frame on a one-cycle
// load strobe and streams it bin by bin (index 0..15) over a valid/ready port.
// Optional macro FFT_SER_SHADOW_EN adds a one-frame shadow buffer so a frame
// loaded mid-stream can follow the current one without a bubble.
module fft_out_serializer #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] in0_re,  in1_re,  in2_re,  in3_re,
  input  logic [WORD_SIZE-1:0] in4_re,  in5_re,  in6_re,  in7_re,
  input  logic [WORD_SIZE-1:0] in8_re,  in9_re,  in10_re, in11_re,
  input  logic [WORD_SIZE-1:0] in12_re, in13_re, in14_re, in15_re,
  input  logic [WORD_SIZE-1:0] in0_im,  in1_im,  in2_im,  in3_im,
  input  logic [WORD_SIZE-1:0] in4_im,  in5_im,  in6_im,  in7_im,
  input  logic [WORD_SIZE-1:0] in8_im,  in9_im,  in10_im, in11_im,
  input  logic [WORD_SIZE-1:0] in12_im, in13_im, in14_im, in15_im,
  input  logic                 load,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] out_re,
  output logic [WORD_SIZE-1:0] out_im,
  output logic [3:0]           out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] in_re [16];
  logic [WORD_SIZE-1:0] in_im [16];
  logic [WORD_SIZE-1:0] frm_re_q [16];
  logic [WORD_SIZE-1:0] frm_re_d [16];
  logic [WORD_SIZE-1:0] frm_im_q [16];
  logic [WORD_SIZE-1:0] frm_im_d [16];
  logic [3:0]           idx_q, idx_d;
  logic                 ovr_q, ovr_d;
  logic                 xfer_last;
`ifdef FFT_SER_SHADOW_EN
  logic [WORD_SIZE-1:0] shd_re_q [16];
  logic [WORD_SIZE-1:0] shd_re_d [16];
  logic [WORD_SIZE-1:0] shd_im_q [16];
  logic [WORD_SIZE-1:0] shd_im_d [16];
  logic                 shd_full_q, shd_full_d;
`endif

  assign in_re = '{in0_re, in1_re, in2_re,  in3_re,  in4_re,  in5_re,  in6_re,  in7_re,
                   in8_re, in9_re, in10_re, in11_re, in12_re, in13_re, in14_re, in15_re};
  assign in_im = '{in0_im, in1_im, in2_im,  in3_im,  in4_im,  in5_im,  in6_im,  in7_im,
                   in8_im, in9_im, in10_im, in11_im, in12_im, in13_im, in14_im, in15_im};

  assign out_valid = (state_q == STREAM);
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == 4'd15);
  assign out_re    = frm_re_q[idx_q];
  assign out_im    = frm_im_q[idx_q];
  assign overrun   = ovr_q;
  assign xfer_last = out_last && out_ready;

`ifdef FFT_SER_SHADOW_EN
  assign busy = out_valid && shd_full_q && !xfer_last;
`else
  assign busy = out_valid && !xfer_last;
`endif

  // Next-state: frame capture/promotion, index advance, FSM and overrun flag
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frm_re_d = frm_re_q;
    frm_im_d = frm_im_q;
    ovr_d    = ovr_q | (load & busy);
`ifdef FFT_SER_SHADOW_EN
    shd_re_d   = shd_re_q;
    shd_im_d   = shd_im_q;
    shd_full_d = shd_full_q;
`endif
    // Index wraps 15->0 naturally; it only leaves 0 again if streaming continues
    if (out_valid && out_ready) idx_d = idx_q + 4'd1;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          frm_re_d = in_re;
          frm_im_d = in_im;
          idx_d    = 4'd0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
`ifdef FFT_SER_SHADOW_EN
        // Shadow frame (if any) is next in line; a coincident load refills it
        if (xfer_last) begin
          if (shd_full_q) begin
            frm_re_d = shd_re_q;
            frm_im_d = shd_im_q;
            if (load) begin
              shd_re_d = in_re;
              shd_im_d = in_im;
            end else begin
              shd_full_d = 1'b0;
            end
          end else if (load) begin
            frm_re_d = in_re;
            frm_im_d = in_im;
          end else begin
            state_d = IDLE;
          end
        end else if (load && !shd_full_q) begin
          shd_re_d   = in_re;
          shd_im_d   = in_im;
          shd_full_d = 1'b1;
        end
`else
        if (xfer_last) begin
          if (load) begin
            frm_re_d = in_re;
            frm_im_d = in_im;
          end else begin
            state_d = IDLE;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        frm_re_q[i] <= '0;
        frm_im_q[i] <= '0;
      end
`ifdef FFT_SER_SHADOW_EN
      shd_full_q <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        shd_re_q[i] <= '0;
        shd_im_q[i] <= '0;
      end
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ovr_q    <= ovr_d;
      frm_re_q <= frm_re_d;
      frm_im_q <= frm_im_d;
`ifdef FFT_SER_SHADOW_EN
      shd_full_q <= shd_full_d;
      shd_re_q   <= shd_re_d;
      shd_im_q   <= shd_im_d;
`endif
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Testbench for fft_out_serializer: directed scenarios plus random traffic,
// checked against a frame-queue reference model.
module tb_fft_out_serializer;

`ifdef FFT_SER_SHADOW_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic        out_ready;
  logic [15:0] in_re [16];
  logic [15:0] in_im [16];
  logic        busy, out_valid, out_last, overrun;
  logic [15:0] out_re, out_im;
  logic [3:0]  out_idx;

  always #5 clk = ~clk;

  fft_out_serializer #(.WORD_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_re(in_re[0]),   .in1_re(in_re[1]),   .in2_re(in_re[2]),   .in3_re(in_re[3]),
    .in4_re(in_re[4]),   .in5_re(in_re[5]),   .in6_re(in_re[6]),   .in7_re(in_re[7]),
    .in8_re(in_re[8]),   .in9_re(in_re[9]),   .in10_re(in_re[10]), .in11_re(in_re[11]),
    .in12_re(in_re[12]), .in13_re(in_re[13]), .in14_re(in_re[14]), .in15_re(in_re[15]),
    .in0_im(in_im[0]),   .in1_im(in_im[1]),   .in2_im(in_im[2]),   .in3_im(in_im[3]),
    .in4_im(in_im[4]),   .in5_im(in_im[5]),   .in6_im(in_im[6]),   .in7_im(in_im[7]),
    .in8_im(in_im[8]),   .in9_im(in_im[9]),   .in10_im(in_im[10]), .in11_im(in_im[11]),
    .in12_im(in_im[12]), .in13_im(in_im[13]), .in14_im(in_im[14]), .in15_im(in_im[15]),
    .load(load), .busy(busy),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .overrun(overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of whole frames (current first, then pending),
  // bin k of a frame packed as {im, re} at bits [32k +: 32].
  logic [511:0] frames [$];
  logic [511:0] nxt_frame;
  int           m_idx = 0;
  logic         m_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) nxt_frame[32*k +: 32] = $urandom;
  endtask

  task automatic ramp_frame();
    for (int k = 0; k < 16; k++) begin
      nxt_frame[32*k +: 16]      = 16'(k);
      nxt_frame[32*k + 16 +: 16] = 16'(0 - k);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model
  task automatic tick(input logic ld, input logic rdy, input logic rst);
    logic         m_valid, m_last, m_lx, m_busy;
    logic [511:0] fr;
    @(negedge clk);
    load      = ld;
    out_ready = rdy;
    rst_n     = !rst;
    for (int k = 0; k < 16; k++) begin
      in_re[k] = nxt_frame[32*k +: 16];
      in_im[k] = nxt_frame[32*k + 16 +: 16];
    end
    #1;
    m_valid = (frames.size() > 0);
    m_last  = m_valid && (m_idx == 15);
    m_lx    = m_last && rdy;
    m_busy  = m_valid && (frames.size() >= CAP) && !m_lx;
    check("valid",   32'(out_valid), 32'(m_valid));
    check("idx",     32'(out_idx),   32'(m_idx));
    check("last",    32'(out_last),  32'(m_last));
    check("busy",    32'(busy),      32'(m_busy));
    check("overrun", 32'(overrun),   32'(m_ovr));
    if (m_valid) begin
      fr = frames[0];
      check("re", 32'(out_re), 32'(fr[32*m_idx +: 16]));
      check("im", 32'(out_im), 32'(fr[32*m_idx + 16 +: 16]));
    end
    @(posedge clk);
    if (rst) begin
      frames.delete();
      m_idx = 0;
      m_ovr = 1'b0;
    end else begin
      if (m_valid && rdy) begin
        if (m_idx == 15) begin
          void'(frames.pop_front());
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (ld) begin
        if (m_busy) m_ovr = 1'b1;
        else frames.push_back(nxt_frame);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; out_ready = 1'b0;
    rand_frame();
    for (int k = 0; k < 16; k++) begin in_re[k] = '0; in_im[k] = '0; end

    // Reset state
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check("rst_re", 32'(out_re), 32'd0);
    check("rst_im", 32'(out_im), 32'd0);

    // Basic ramp stream, ready held high
    ramp_frame();
    tick(1'b1, 1'b1, 1'b0);
    repeat (18) tick(1'b0, 1'b1, 1'b0);

    // Backpressure at idx 5 for 3 cycles
    rand_frame();
    tick(1'b1, 1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    repeat (12) tick(1'b0, 1'b1, 1'b0);

    // Back-to-back: load B on the idx-15 transfer of A
    rand_frame();
    tick(1'b1, 1'b1, 1'b0);
    repeat (15) tick(1'b0, 1'b1, 1'b0);
    rand_frame();
    tick(1'b1, 1'b1, 1'b0);
    repeat (17) tick(1'b0, 1'b1, 1'b0);

    // Mid-stream loads at idx 3 and idx 7
    rand_frame();
    tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    rand_frame();
    tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    rand_frame();
    tick(1'b1, 1'b1, 1'b0);
    repeat (40) tick(1'b0, 1'b1, 1'b0);

    // Reset mid-frame at idx 9
    rand_frame();
    tick(1'b1, 1'b1, 1'b0);
    repeat (9) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    repeat (4) tick(1'b0, 1'b1, 1'b0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rand_frame();
      tick($urandom_range(7) == 0, $urandom_range(3) != 0, $urandom_range(249) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_out_serializer.md
FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001 The module SHALL have parameter WORD_SIZE, default 16, which sets the width of each real and imaginary sample word.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have ports in0_re..in15_re, input, WORD_SIZE bits each: real parts of the scaled, reordered spectrum frame, two's complement.
REQ-005 The module SHALL have ports in0_im..in15_im, input, WORD_SIZE bits each: imaginary parts of the same frame.
REQ-006 The module SHALL have port load, input, 1 bit: a one-cycle frame strobe; when accepted, all 32 words are captured on this edge.
REQ-007 The module SHALL have port busy, output, 1 bit: when high, a load in this cycle is not accepted.
REQ-008 The module SHALL have ports out_re and out_im, output, WORD_SIZE bits each: the current streamed sample.
REQ-009 The module SHALL have port out_idx, output, 4 bits: the bin index (0..15) of the current sample.
REQ-010 The module SHALL have port out_valid, output, 1 bit: out_re, out_im, out_idx and out_last are valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the sample.
REQ-012 The module SHALL have port out_last, output, 1 bit: high while out_idx = 15 and out_valid = 1.
REQ-013 The module SHALL have port overrun, output, 1 bit: a sticky flag set when a load is dropped.

Function
REQ-014 The FSM SHALL have two states, IDLE and STREAM; IDLE→STREAM on an accepted load; STREAM→IDLE on the idx-15 transfer when no next frame is pending.
REQ-015 An accepted load at edge N SHALL give out_valid = 1 and out_idx = 0 from cycle N+1, a latency of 1.
REQ-016 A transfer SHALL occur on an edge where out_valid && out_ready; out_idx then increments by 1.
REQ-017 While out_valid && !out_ready, out_re, out_im, out_idx and out_last SHALL hold stable.
REQ-018 Data SHALL pass bit-exact with no arithmetic, sign change or width change; out_idx = k SHALL carry ink_re and ink_im of the captured frame.
REQ-019 out_idx SHALL wrap 15→0 only when a next frame starts; otherwise it holds 0 in IDLE.
REQ-020 On the idx-15 transfer with a next frame available, out_idx 0 of that frame SHALL be valid on the next cycle with no bubble.
REQ-021 A load in the same cycle as the idx-15 transfer SHALL be accepted and SHALL count as the next frame, so busy is low in that cycle.
REQ-022 A load while busy SHALL be dropped, SHALL set overrun, and SHALL leave the in-flight frame unaffected.
REQ-023 In IDLE, out_valid SHALL be 0 and out_ready SHALL be ignored.

Reset
REQ-024 While rst_n = 0 at an edge, the state SHALL go to IDLE and every output SHALL reset: out_re = 0, out_im = 0, out_idx = 0, out_valid = 0, out_last = 0, overrun = 0, busy = 0.
REQ-025 Reset mid-frame SHALL discard all captured and pending frames; load is ignored while rst_n = 0.

Configuration
REQ-026 With macro FFT_SER_SHADOW_EN defined, a one-frame shadow buffer SHALL exist: a load during STREAM is captured into the shadow if it is empty.
REQ-027 With FFT_SER_SHADOW_EN defined, busy = STREAM && shadow full && !(idx-15 transfer this cycle), and the shadow SHALL be promoted on the idx-15 transfer.
REQ-028 Without FFT_SER_SHADOW_EN, no shadow SHALL exist and busy = STREAM && !(idx-15 transfer this cycle).

Verification
REQ-029 Basic stream: load frame with ink_re = k, ink_im = -k and out_ready held 1 → 16 consecutive beats with idx 0..15, re = 0..15, im = 0,-1..-15 (0xFFF1 at idx 15), out_last only at idx 15, then out_valid = 0.
REQ-030 Backpressure: deassert out_ready for 3 cycles at idx 5 → idx 5 data held unchanged for those 3 cycles, then the stream resumes at idx 6; 16 beats total.
REQ-031 Back-to-back: assert load with frame B on the idx-15 transfer of frame A → B idx 0 is valid on the next cycle; overrun stays 0.
REQ-032 Overrun, shadow disabled: load at idx 3 → load dropped, overrun = 1, frame A completes intact, then IDLE.
REQ-033 Overrun, shadow enabled: load B at idx 3, then load C at idx 7 → B streams right after A, C is dropped, overrun = 1.
REQ-034 Reset: rst_n = 0 for 1 cycle at idx 9 → next cycle out_valid = 0, out_idx = 0, overrun = 0, and no remaining beats of that frame appear.
